sobol_index_seq: RTL and testbench
==================================

Name: sobol_index_seq

Overview:
- Upstream sequencer for the Sobol generator.
- Walks a programmable block of paths × time-steps and emits one (idx, dim) request per beat on a valid/ready interface, in path-major order: path p, dims 0..last; then path p+1.
- Carries path-relative and last-beat tags so downstream stages can frame per-path vectors.
- Sustains one beat per cycle under no backpressure.

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH, width of path index and path count
- M, 50, number of time-step dimensions; local DW = $clog2(M) is the dim field width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch a run; sampled only in IDLE
- abort  in  1  synchronous cancel of the current run
- first_idx  in  WIDTH  Sobol index of first path; 0 is legal, caller normally uses 1 to skip the origin
- n_paths  in  WIDTH  number of paths to emit
- last_dim  in  DW  highest dim per path, range 0..M-1
- valid_out  out  1  request valid
- ready_in  in  1  downstream accepts
- idx_out  out  WIDTH  Sobol index for this beat
- dim_out  out  DW  time-step for this beat
- path_out  out  WIDTH  path number relative to run start
- last_dim_out  out  1  beat is the final dim of its path
- last_out  out  1  beat is the final beat of the run
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; valid_out=0, busy=0, done=0; idx_out/dim_out/path_out=0; last_dim_out/last_out=0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - On start=1, latch first_idx, n_paths and last_dim. If last_dim>M-1, clamp to M-1.
  - If n_paths==0: pulse done next cycle, stay IDLE, emit no beats, leave busy=0.
  - Otherwise: busy=1, and the first beat (idx=first_idx, dim=0, path=0) is valid on the next cycle (latency 1). Go to RUN.
- RUN:
  - Output is a single register stage. It loads the next beat when !valid_out || ready_in, so it is full throughput with ready_in held high.
  - Outputs are held stable while valid_out && !ready_in.
  - Counters: dim increments 0..last_dim_latched, then wraps to 0 while path increments.
  - idx_out = first_idx + path_out modulo 2^WIDTH; wrap past all-ones is silent.
  - last_dim_out = (dim==last_dim_latched).
  - last_out = last_dim_out && (path==n_paths-1).
  - After loading the beat with last_out=1, go to FLUSH.
- FLUSH:
  - Hold the final beat until ready_in.
  - On acceptance: valid_out=0, done=1 for exactly one cycle, busy=0, go to IDLE.
  - Back-to-back: a start asserted in the done cycle is ignored. It is accepted only from the next IDLE cycle.
- abort:
  - Highest priority in RUN/FLUSH. The next cycle has valid_out=0, busy=0, state IDLE, and no done pulse.
  - Any beat held un-accepted is dropped.
  - In IDLE, abort has no effect; if start and abort are both high in IDLE, start wins.
- start while busy: ignored, and the latched config is unchanged.
- Config inputs: changes to first_idx, n_paths or last_dim mid-run are ignored; only the latched values are used.
- Beat count per run: exactly n_paths × (last_dim+1), with no duplicates or gaps under any ready_in pattern.
- valid_out never drops without acceptance except on abort or reset.
- dim_out < M always holds.

Test Plan:
- Basic run: first_idx=1, n_paths=3, last_dim=2, ready_in=1.
  - Expect 9 consecutive beats: idx 1,1,1,2,2,2,3,3,3 and dim 0,1,2 repeating.
  - last_dim_out on beats 3, 6 and 9; last_out on beat 9 only.
  - done pulses the cycle after beat 9; valid_out first rises 1 cycle after start.
- Backpressure: same config with ready_in toggled pseudo-randomly.
  - Scoreboard sees the identical 9-beat sequence.
  - Outputs are stable during every stalled cycle; done comes exactly once.
- Boundaries:
  - n_paths=0 → zero beats, done pulse 1 cycle after start, busy stays 0.
  - last_dim=0, n_paths=1 → a single beat with last_dim_out=1 and last_out=1.
  - last_dim=63 with M=50 → dims run 0..49.
- Wrap: WIDTH=16, first_idx=16'hFFFE, n_paths=4, last_dim=0 → idx FFFE, FFFF, 0000, 0001, with path_out 0..3.
- Abort: assert abort during the 5th beat with ready_in=0.
  - valid_out=0 and busy=0 next cycle, no done pulse.
  - A subsequent start runs a fresh sequence from path 0.
- Reset mid-run: drop rst_n during RUN → outputs go to reset values immediately (async). After release, no beat is emitted until a new start.

Source files
------------

// File: rtl/sobol_index_seq.sv
// sobol_index_seq: walks paths x time-steps and emits (idx, dim) requests in
// path-major order on a valid/ready stream, with per-path and end-of-run tags.

package fpga_cfg_pkg;
  localparam int FP_WIDTH = 16;
endpackage

`default_nettype none

module sobol_index_seq #(
  parameter int  WIDTH = fpga_cfg_pkg::FP_WIDTH,
  parameter int  M     = 50,
  localparam int DW    = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] first_idx,
  input  logic [WIDTH-1:0] n_paths,
  input  logic [DW-1:0]    last_dim,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] idx_out,
  output logic [DW-1:0]    dim_out,
  output logic [WIDTH-1:0] path_out,
  output logic             last_dim_out,
  output logic             last_out,
  output logic             busy,
  output logic             done
);

  localparam logic [DW-1:0] DIM_MAX = DW'(M - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] npaths_q, npaths_d;
  logic [DW-1:0]    lastdim_q, lastdim_d;
  logic [DW-1:0]    dim_cnt_q, dim_cnt_d;
  logic [WIDTH-1:0] path_cnt_q, path_cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0]    dim_q, dim_d;
  logic [WIDTH-1:0] path_q, path_d;
  logic             ldo_q, ldo_d;
  logic             lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DW-1:0]    cfg_lastdim;
  logic             is_idle;
  logic [WIDTH-1:0] src_first, src_npaths, src_path;
  logic [DW-1:0]    src_lastdim, src_dim;
  logic             src_last_dim, src_last;

  assign cfg_lastdim = (last_dim > DIM_MAX) ? DIM_MAX : last_dim;

  // In IDLE the first beat is built straight from the live config so it can
  // appear one cycle after start; afterwards only latched values are used.
  assign is_idle      = (state_q == S_IDLE);
  assign src_first    = is_idle ? first_idx   : first_q;
  assign src_npaths   = is_idle ? n_paths     : npaths_q;
  assign src_lastdim  = is_idle ? cfg_lastdim : lastdim_q;
  assign src_dim      = is_idle ? '0          : dim_cnt_q;
  assign src_path     = is_idle ? '0          : path_cnt_q;
  assign src_last_dim = (src_dim == src_lastdim);
  assign src_last     = src_last_dim && (src_path == src_npaths - WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    npaths_d   = npaths_q;
    lastdim_d  = lastdim_q;
    dim_cnt_d  = dim_cnt_q;
    path_cnt_d = path_cnt_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    dim_d      = dim_q;
    path_d     = path_q;
    ldo_d      = ldo_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start arriving in the done cycle is deliberately not accepted.
        if (start && !done_q) begin
          first_d   = first_idx;
          npaths_d  = n_paths;
          lastdim_d = cfg_lastdim;
          if (n_paths == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ready_in) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((is_idle && start && !done_q && (n_paths != '0)) ||
        ((state_q == S_RUN) && !abort && (!valid_q || ready_in))) begin
      valid_d = 1'b1;
      idx_d   = src_first + src_path;
      dim_d   = src_dim;
      path_d  = src_path;
      ldo_d   = src_last_dim;
      lo_d    = src_last;
      if (src_last_dim) begin
        dim_cnt_d  = '0;
        path_cnt_d = src_path + WIDTH'(1);
      end else begin
        dim_cnt_d  = src_dim + DW'(1);
        path_cnt_d = src_path;
      end
      state_d = src_last ? S_FLUSH : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      first_q    <= '0;
      npaths_q   <= '0;
      lastdim_q  <= '0;
      dim_cnt_q  <= '0;
      path_cnt_q <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      dim_q      <= '0;
      path_q     <= '0;
      ldo_q      <= 1'b0;
      lo_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      npaths_q   <= npaths_d;
      lastdim_q  <= lastdim_d;
      dim_cnt_q  <= dim_cnt_d;
      path_cnt_q <= path_cnt_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      dim_q      <= dim_d;
      path_q     <= path_d;
      ldo_q      <= ldo_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign valid_out    = valid_q;
  assign idx_out      = idx_q;
  assign dim_out      = dim_q;
  assign path_out     = path_q;
  assign last_dim_out = ldo_q;
  assign last_out     = lo_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sobol_index_seq.sv
// tb_sobol_index_seq: directed runs with a queue scoreboard and a decoupled
// monitor that also checks stall stability and done timing.

`default_nettype none

module tb_sobol_index_seq;

  localparam int WIDTH = 16;
  localparam int M     = 50;
  localparam int DW    = $clog2(M);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ready_in = 1'b0;
  logic [WIDTH-1:0] first_idx = '0;
  logic [WIDTH-1:0] n_paths = '0;
  logic [DW-1:0]    last_dim = '0;
  logic             valid_out, last_dim_out, last_out, busy, done;
  logic [WIDTH-1:0] idx_out, path_out;
  logic [DW-1:0]    dim_out;

  sobol_index_seq #(.WIDTH(WIDTH), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_idx(first_idx), .n_paths(n_paths), .last_dim(last_dim),
    .valid_out(valid_out), .ready_in(ready_in), .idx_out(idx_out),
    .dim_out(dim_out), .path_out(path_out), .last_dim_out(last_dim_out),
    .last_out(last_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] idx;
    logic [DW-1:0]    dim;
    logic [WIDTH-1:0] path;
    logic             ld;
    logic             lo;
  } beat_t;

  beat_t sb[$];
  int    tests = 0, fails = 0;
  int    done_cnt = 0, cyc = 0, last_cyc = -1;
  bit    sb_en = 1'b1;
  int    rdy_mode = 0;
  logic  rdy_man = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ready_in source: 0 = always high, 1 = pseudo-random, 2 = manual
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       ready_in = 1'b1;
      1:       ready_in = 1'($urandom_range(0, 1));
      default: ready_in = rdy_man;
    endcase
  end

  // Monitor: pops expectations on accepted beats, checks stalls and done timing.
  initial begin
    beat_t cur, held_b, e;
    bit    held = 1'b0;
    logic  abort_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {idx_out, dim_out, path_out, last_dim_out, last_out};
      if (sb_en) begin
        if (held && !abort_prev)
          chk("stall_hold", {23'd0, valid_out, cur}, {23'd0, 1'b1, held_b});
        if (valid_out && ready_in) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %0h expected none", cur);
          end else begin
            e = sb.pop_front();
            chk("beat", cur, e);
            if (e.lo) last_cyc = cyc;
          end
        end
        held       = valid_out && !ready_in;
        held_b     = cur;
        abort_prev = abort;
      end else begin
        held = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (last_cyc >= 0) begin
          chk("done_timing", cyc, last_cyc + 1);
          last_cyc = -1;
        end
      end
    end
  end

  task automatic push_run(input int first, input int n, input int ld);
    int eld;
    eld = (ld > M - 1) ? M - 1 : ld;
    for (int p = 0; p < n; p++)
      for (int d = 0; d <= eld; d++)
        sb.push_back({WIDTH'(first + p), DW'(d), WIDTH'(p), d == eld, (d == eld) && (p == n - 1)});
  endtask

  task automatic do_start(input int first, input int n, input int ld);
    @(posedge clk);
    #1;
    first_idx = WIDTH'(first);
    n_paths   = WIDTH'(n);
    last_dim  = DW'(ld);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    first_idx = WIDTH'($urandom);
    n_paths   = WIDTH'($urandom);
    last_dim  = DW'($urandom);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_busy_low"}, busy, 0);
  endtask

  task automatic check_done_once(input string name, input int d0);
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, done_cnt, d0 + 1);
  endtask

  initial begin
    int   d0;
    logic seen;

    // Reset state
    #1;
    chk("reset_outputs", {valid_out, idx_out, dim_out, path_out, last_dim_out, last_out, busy, done}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic run, latency 1
    rdy_mode = 0;
    d0 = done_cnt;
    push_run(1, 3, 2);
    do_start(1, 3, 2);
    @(negedge clk);
    chk("first_beat_latency", {valid_out, busy}, 2'b11);
    wait_done("basic");
    check_done_once("basic", d0);

    // Backpressure with a start pulse while busy
    rdy_mode = 1;
    d0 = done_cnt;
    push_run(1, 3, 2);
    do_start(1, 3, 2);
    @(posedge clk);
    #1;
    first_idx = 16'h0100;
    n_paths   = 16'd7;
    last_dim  = 6'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("backpressure");
    check_done_once("backpressure", d0);
    rdy_mode = 0;

    // n_paths = 0
    d0 = done_cnt;
    do_start(7, 0, 3);
    @(negedge clk);
    chk("zero_paths_done", {done, valid_out, busy}, 3'b100);
    @(negedge clk);
    chk("zero_paths_idle", {done, valid_out, busy}, 3'b000);
    chk("zero_paths_done_cnt", done_cnt, d0 + 1);

    // Single beat
    push_run(9, 1, 0);
    do_start(9, 1, 0);
    wait_done("single");

    // last_dim clamp
    push_run(5, 2, 63);
    do_start(5, 2, 63);
    wait_done("clamp");

    // Index wrap
    push_run(16'hFFFE, 4, 0);
    do_start(16'hFFFE, 4, 0);
    wait_done("wrap");

    // Abort while 5th beat is stalled
    rdy_mode = 2;
    rdy_man  = 1'b0;
    d0 = done_cnt;
    push_run(1, 3, 2);
    repeat (5) void'(sb.pop_back());
    do_start(1, 3, 2);
    rdy_man = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rdy_man = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_held_beat", {valid_out, dim_out, path_out}, {1'b1, 6'd1, 16'd1});
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {valid_out, busy}, 2'b00);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_drained", sb.size(), 0);
    rdy_mode = 0;

    // Fresh run after abort, then a start in the done cycle
    push_run(1, 3, 2);
    do_start(1, 3, 2);
    wait_done("after_abort");
    start     = 1'b1;
    first_idx = 16'd3;
    n_paths   = 16'd1;
    last_dim  = 6'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_start_ignored", {valid_out, busy}, 2'b00);

    // Reset mid-run
    sb_en = 1'b0;
    do_start(1, 10, 3);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {valid_out, idx_out, dim_out, path_out, last_dim_out, last_out, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid_out || busy) seen = 1'b1;
    end
    chk("no_beat_after_reset", seen, 0);
    sb_en = 1'b1;

    push_run(2, 2, 1);
    do_start(2, 2, 1);
    wait_done("post_reset");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
